// File: rtl/sliding_window_11x11_pkg.sv
// Shared types and sizes for the 11x11 window generator.
// Pixel and window-row types plus a helper for debug-friendly counter widths.
package sliding_window_11x11_pkg;

    localparam int PIX_W  = 8;
    localparam int WIN    = 11;
    localparam int NUM_LB = 10;
    localparam int CNT_W  = 21;

    typedef logic [PIX_W-1:0]            pix_t;
    typedef logic [WIN-1:0][PIX_W-1:0]   win_row_t;
    typedef logic [CNT_W-1:0]            cnt_t;

    typedef struct packed {
        logic start_flag;
        logic complete;
        logic complete2;
        logic complete1;
    } flags_t;

    // Counters are at least 8 bits wide so the 8-bit debug taps can slice them directly.
    function automatic int ctr_width(input int max_count);
        return (max_count > 256) ? $clog2(max_count) : 8;
    endfunction

endpackage

// File: rtl/sliding_window_11x11_if.sv
// Pixel stream in, 11 window rows plus priming/debug status out.
// slave is the window generator side, master is the stream source / consumer side.
interface sliding_window_11x11_if;
    import sliding_window_11x11_pkg::*;

    pix_t               din;
    win_row_t [WIN:1]   dout;
    pix_t               test1;
    pix_t               test2;
    logic [7:0]         test_cnt1;
    logic [7:0]         test_cnt2;
    logic               start_flag;
    cnt_t               cnt;
    logic               complete1;
    logic               complete2;
    logic               complete;

    modport slave (
        input  din,
        output dout, test1, test2, test_cnt1, test_cnt2,
        output start_flag, cnt, complete1, complete2, complete
    );

    modport master (
        output din,
        input  dout, test1, test2, test_cnt1, test_cnt2,
        input  start_flag, cnt, complete1, complete2, complete
    );

endinterface

// File: rtl/sliding_window_11x11_line_buffer.sv
// Fixed DEPTH-pixel delay built on a circular RAM; read-before-write, combinational read.
// Latency DEPTH accepted pixels; no backpressure, writes every cycle outside reset.
module sliding_window_11x11_line_buffer
    import sliding_window_11x11_pkg::*;
#(
    parameter int DEPTH = 640
) (
    input  logic clk,
    input  logic rst,
    input  pix_t wr_dat_i,
    output pix_t rd_dat_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pix_t          mem_q [DEPTH];
    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // The slot about to be overwritten holds the pixel written DEPTH cycles ago.
    assign rd_dat_o = mem_q[ptr_q];
    assign ptr_d    = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q[ptr_q] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/sliding_window_11x11.sv
// Streaming 11x11 window generator: 10 chained line buffers feed 11 row shift registers.
// Latency 1 cycle din -> dout11[7:0]; no backpressure, one pixel accepted every cycle.
module sliding_window_11x11
    import sliding_window_11x11_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic                   clk,
    input  logic                   rst,
    sliding_window_11x11_if.slave  win_if
);

    localparam int   CW         = ctr_width(IMG_W);
    localparam int   RW         = ctr_width(IMG_H);
    localparam int   TH_LB1     = IMG_W - 1;
    localparam int   TH_LB2     = 2 * IMG_W - 1;
    localparam int   TH_ALL     = NUM_LB * IMG_W - 1;
    localparam int   TH_WIN     = NUM_LB * IMG_W + WIN - 1;
    localparam int   PW         = $clog2(TH_WIN + 1);
    localparam cnt_t FRAME_LAST = cnt_t'(IMG_W * IMG_H - 1);

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    cnt_t             cnt_q, cnt_d;
    logic [PW-1:0]    prime_q, prime_d;
    flags_t           flags_q, flags_d;
    pix_t             test1_q, test2_q;
    win_row_t [WIN:1] rows_q, rows_d;

    pix_t lb_in  [1:NUM_LB];
    pix_t lb_dat [1:NUM_LB];

    for (genvar i = 1; i <= NUM_LB; i++) begin : g_lb
        if (i == 1) begin : g_head
            assign lb_in[i] = win_if.din;
        end else begin : g_link
            assign lb_in[i] = lb_dat[i-1];
        end

        sliding_window_11x11_line_buffer #(
            .DEPTH (IMG_W)
        ) u_lb (
            .clk      (clk),
            .rst      (rst),
            .wr_dat_i (lb_in[i]),
            .rd_dat_o (lb_dat[i])
        );
    end

    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == CW'(IMG_W - 1)) begin
            col_d = '0;
            row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
        end

        cnt_d = (cnt_q == FRAME_LAST) ? '0 : cnt_q + 1'b1;

        // Priming count is independent of the frame counter so flags survive frame wrap.
        prime_d = (prime_q == PW'(TH_WIN)) ? prime_q : prime_q + 1'b1;
        flags_d = flags_q;
        if (prime_q == PW'(TH_LB1)) flags_d.complete1  = 1'b1;
        if (prime_q == PW'(TH_LB2)) flags_d.complete2  = 1'b1;
        if (prime_q == PW'(TH_ALL)) flags_d.complete   = 1'b1;
        if (prime_q == PW'(TH_WIN)) flags_d.start_flag = 1'b1;

        rows_d[WIN] = {rows_q[WIN][WIN-2:0], win_if.din};
        for (int k = 1; k < WIN; k++) begin
            rows_d[k] = {rows_q[k][WIN-2:0], lb_dat[WIN-k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            prime_q <= '0;
            flags_q <= '0;
            test1_q <= '0;
            test2_q <= '0;
            rows_q  <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            prime_q <= prime_d;
            flags_q <= flags_d;
            test1_q <= lb_dat[1];
            test2_q <= lb_dat[2];
            rows_q  <= rows_d;
        end
    end

    assign win_if.dout       = rows_q;
    assign win_if.test1      = test1_q;
    assign win_if.test2      = test2_q;
    assign win_if.test_cnt1  = col_q[7:0];
    assign win_if.test_cnt2  = row_q[7:0];
    assign win_if.cnt        = cnt_q;
    assign win_if.complete1  = flags_q.complete1;
    assign win_if.complete2  = flags_q.complete2;
    assign win_if.complete   = flags_q.complete;
    assign win_if.start_flag = flags_q.start_flag;

endmodule

// File: tb/tb_sliding_window_11x11.sv
// Bench for the 11x11 window generator at IMG_W=IMG_H=16: ramp, mid-stream reset, random pixels.
// Expected values come from a pixel-history array indexed by the window formula.
module tb_sliding_window_11x11;
    import sliding_window_11x11_pkg::*;

    localparam int W = 16;
    localparam int H = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sliding_window_11x11_if win_if ();

    sliding_window_11x11 #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .win_if (win_if)
    );

    int         errors = 0;
    int         checks = 0;
    int         n      = 0;
    logic [7:0] hist [0:4095];

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        win_if.din = v;
        @(posedge clk);
        #1;
        hist[n] = v;
        n++;
    endtask

    task automatic pulse_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        n   = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_cnt"},   88'(win_if.cnt),        88'(0));
        chk({tag, "_col"},   88'(win_if.test_cnt1),  88'(0));
        chk({tag, "_row"},   88'(win_if.test_cnt2),  88'(0));
        chk({tag, "_c1"},    88'(win_if.complete1),  88'(0));
        chk({tag, "_c2"},    88'(win_if.complete2),  88'(0));
        chk({tag, "_c"},     88'(win_if.complete),   88'(0));
        chk({tag, "_start"}, 88'(win_if.start_flag), 88'(0));
        chk({tag, "_t1"},    88'(win_if.test1),      88'(0));
        chk({tag, "_t2"},    88'(win_if.test2),      88'(0));
        chk({tag, "_d11"},   88'(win_if.dout[11]),   88'(0));
    endtask

    // Compare every output against the pixel history after the latest accepted pixel.
    task automatic check_model();
        int         p;
        logic [87:0] e;
        p = n - 1;
        chk("cnt",   88'(win_if.cnt),        88'(n % (W * H)));
        chk("col",   88'(win_if.test_cnt1),  88'(n % W));
        chk("row",   88'(win_if.test_cnt2),  88'((n / W) % H));
        chk("c1",    88'(win_if.complete1),  88'(n >= W));
        chk("c2",    88'(win_if.complete2),  88'(n >= 2 * W));
        chk("c",     88'(win_if.complete),   88'(n >= 10 * W));
        chk("start", 88'(win_if.start_flag), 88'(n >= 10 * W + 11));
        if (p >= W)     chk("test1", 88'(win_if.test1), 88'(hist[p - W]));
        if (p >= 2 * W) chk("test2", 88'(win_if.test2), 88'(hist[p - 2 * W]));
        if (n >= 10 * W + 11) begin
            for (int k = 1; k <= 11; k++) begin
                e = '0;
                for (int j = 0; j < 11; j++) e[8*j +: 8] = hist[p - j - (11 - k) * W];
                chk($sformatf("dout%0d", k), 88'(win_if.dout[k]), e);
            end
        end
    endtask

    initial begin
        int p;
        win_if.din = '0;

        pulse_reset(5);
        check_reset("rst");

        for (int i = 0; i < 300; i++) begin
            push(8'(n % 201));
            check_model();
            p = n - 1;
            if (p == 14)  chk("c1_before", 88'(win_if.complete1), 88'(0));
            if (p == 15) begin
                chk("c1_set",  88'(win_if.complete1), 88'(1));
                chk("cnt_16",  88'(win_if.cnt),       88'(16));
            end
            if (p == 31)  chk("c2_set", 88'(win_if.complete2), 88'(1));
            if (p == 159) begin
                chk("c_set",        88'(win_if.complete),   88'(1));
                chk("start_not_yet", 88'(win_if.start_flag), 88'(0));
            end
            if (p == 169) chk("start_169", 88'(win_if.start_flag), 88'(0));
            if (p == 170) begin
                chk("start_set",  88'(win_if.start_flag),  88'(1));
                chk("d11_new",    88'(win_if.dout[11][0]), 88'(170));
                chk("d11_old",    88'(win_if.dout[11][10]), 88'(160));
                chk("d1_new",     88'(win_if.dout[1][0]),  88'(10));
                chk("d1_old",     88'(win_if.dout[1][10]), 88'(0));
                chk("t1_170",     88'(win_if.test1),       88'(154));
                chk("t2_170",     88'(win_if.test2),       88'(138));
            end
            if (p == 210) begin
                chk("ramp_wrap0", 88'(win_if.dout[11][0]), 88'(9));
                chk("ramp_wrap1", 88'(win_if.dout[11][1]), 88'(8));
            end
            if (p == 255) begin
                chk("frame_cnt",   88'(win_if.cnt),        88'(0));
                chk("frame_row",   88'(win_if.test_cnt2),  88'(0));
                chk("frame_start", 88'(win_if.start_flag), 88'(1));
                chk("frame_c",     88'(win_if.complete),   88'(1));
                chk("frame_c1",    88'(win_if.complete1),  88'(1));
            end
        end

        pulse_reset(1);
        check_reset("rst2");
        for (int i = 0; i <= 100; i++) begin
            push(8'(n % 201));
            check_model();
        end

        pulse_reset(1);
        check_reset("mid");
        for (int i = 0; i < 16; i++) begin
            push(8'(n % 201));
            if (i == 14) chk("mid_c1_before", 88'(win_if.complete1), 88'(0));
            if (i == 15) chk("mid_c1_set",    88'(win_if.complete1), 88'(1));
            check_model();
        end

        for (int i = 0; i < 600; i++) begin
            push(8'($urandom_range(0, 255)));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
